cs8_axis_packer: RTL and testbench
==================================

Name: cs8_axis_packer

Overview:
- Consumes the packed 16-bit cs8 IQ word produced by the 12-to-8-bit sample reducer (Q in [15:8], I in [7:0]).
- Packs two consecutive IQ words into one 32-bit AXI4-Stream beat and buffers beats in a small FIFO.
- Delimits fixed-length packets with tlast for the DMA.
- Input side has no backpressure (ADC-paced). Overflow drops data and is flagged, never stalls.

Parameters:
- FIFO_DEPTH, 8, beats of buffering; power of two, >= 2.
- PKT_LEN, 1024, beats per packet; tlast on beat PKT_LEN-1; >= 1.

Ports:
- clk  in  1  stream clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable
- in_valid  in  1  in_data holds a sample this cycle
- in_data  in  16  cs8 IQ word {Q[7:0], I[7:0]}
- m_axis_tdata  out  32  {second sample, first sample}
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet
- overflow  out  1  sticky: a beat was dropped
- overflow_clr  in  1  clears overflow
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release on clk): all outputs 0; half-pair flag cleared; FIFO empty; beat counter 0.
- Pair state machine, 2 states:
  - EVEN: in_valid & enable latches in_data into the hold register and moves to ODD.
  - ODD: in_valid & enable forms {in_data, hold} and pushes it on the same edge, then returns to EVEN.
- enable low: in_valid ignored; state forced to EVEN, so any partial pair is discarded. FIFO keeps draining and the beat counter is not reset.
- Latency: second sample presented in cycle n with FIFO empty gives m_axis_tvalid=1 and tdata valid in cycle n+1.
- Output: show-ahead FIFO. tdata and tlast come from registers/memory, not from the inputs.
  - tdata and tvalid are held stable until a handshake (tvalid & tready).
- tlast: asserted when beat_cnt == PKT_LEN-1 while tvalid.
  - beat_cnt increments only on a handshake and wraps PKT_LEN-1 -> 0.
  - Dropped beats do not advance beat_cnt, so packet length is always exactly PKT_LEN delivered beats.
- Full FIFO:
  - A push with no simultaneous pop drops the new beat and sets overflow.
  - A push and pop in the same cycle when full both succeed; level is unchanged.
- Empty FIFO: no pop occurs and tvalid=0. A push in the same cycle becomes visible the next cycle (no bypass).
- fifo_level: +1 on push only, -1 on pop only, unchanged for both or neither.
- overflow: stays set until overflow_clr. If a drop and overflow_clr occur in the same cycle, set wins.
- Pointers: $clog2(FIFO_DEPTH)+1 bits; full and empty are decided by MSB compare.

Optional Feature:
- Macro: CS8_AXIS_PACKER_DROP_CNT_EN
- Defined: adds output port drop_count [31:0].
  - Increments once per dropped beat and saturates at 0xFFFFFFFF.
  - Cleared by rst and by overflow_clr. If overflow_clr and a drop occur in the same cycle, the result is 1.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package cs8_pkg:
  - CS8_W=8, IQ_W=16, BEAT_W=32
  - typedef iq_word_t [15:0], typedef beat_t [31:0]
  - pair_state_t enum {PAIR_EVEN, PAIR_ODD}
- Sub-module cs8_sync_fifo: parameterised width/depth, show-ahead, push/pop/full/empty/level.
  - The packer instantiates it at width 32.
  - Pair FSM, beat counter, overflow and drop logic stay in the top level.

Test Plan:
- Continuous in_valid with samples 0x0101, 0x0202, 0x0303, 0x0404 and tready=1 -> beats 0x02020101 then 0x04040303. First beat tvalid exactly 1 cycle after the 0x0202 input.
- PKT_LEN=4, 16 samples, tready=1 -> 8 beats, with tlast on beats 3 and 7 only.
- enable dropped after one sample (0x1111), re-enabled, then 0xAAAA, 0xBBBB -> single beat 0xBBBBAAAA; 0x1111 never appears.
- FIFO_DEPTH=4, tready=0, 12 samples -> 4 beats retained, overflow=1, fifo_level=4. Releasing tready yields the first 4 beats in order. With the macro defined, drop_count=2.
- FIFO full with tready=1 and a push on the same cycle -> no drop, overflow stays 0, level stays 4.
- rst pulsed mid-packet with tvalid high -> tvalid, tlast, overflow and fifo_level go to 0 immediately (asynchronously). The next packet's tlast lands after exactly PKT_LEN beats.

Source files
------------

// File: rtl/cs8_axis_packer_pkg.sv
// Shared widths, word types and pair-state encoding for the cs8 AXI4-Stream packer.
package cs8_pkg;

  localparam int CS8_W  = 8;
  localparam int IQ_W   = 16;
  localparam int BEAT_W = 32;

  typedef logic [IQ_W-1:0]   iq_word_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic {
    PAIR_EVEN,
    PAIR_ODD
  } pair_state_t;

endpackage

// File: rtl/cs8_axis_packer_if.sv
// Sample input and AXI4-Stream output bundle of the cs8 packer.
// The packer uses the master modport; the sample source / sink side uses slave.
interface cs8_axis_packer_if;
  import cs8_pkg::*;

  logic     in_valid;
  iq_word_t in_data;
  beat_t    m_axis_tdata;
  logic     m_axis_tvalid;
  logic     m_axis_tready;
  logic     m_axis_tlast;

  modport master (
    input  in_valid,
    input  in_data,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport slave (
    output in_valid,
    output in_data,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );

endinterface

// File: rtl/cs8_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one wrap bit so full/empty
// come from an MSB compare; rdata reads 0 while empty.
module cs8_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  // pointer advance on accepted push / pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // storage write; contents need no reset since rdata is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cs8_axis_packer.sv
// Packs pairs of cs8 IQ words into 32-bit AXI4-Stream beats with fixed-length
// tlast framing. The sample side cannot be stalled: beats arriving at a full
// FIFO are dropped and flagged on the sticky overflow output.
// Build option CS8_AXIS_PACKER_DROP_CNT_EN adds a saturating drop_count port.
//
// state     | meaning
// PAIR_EVEN | waiting for the first sample of a pair
// PAIR_ODD  | first sample held; next sample completes the beat
module cs8_axis_packer
  import cs8_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  cs8_axis_packer_if.master             bus,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
  , output logic [31:0]                 drop_count
`endif
);
  localparam int               CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  pair_state_t      state_q, state_d;
  iq_word_t         hold_q;
  logic             hold_en, push, pop, drop, full, empty;
  beat_t            push_data;
  logic [CNT_W-1:0] beat_cnt;

  assign push_data         = {bus.in_data, hold_q};
  assign pop               = ~empty & bus.m_axis_tready;
  assign drop              = push & full & ~pop;
  assign bus.m_axis_tvalid = ~empty;
  assign bus.m_axis_tlast  = ~empty & (beat_cnt == LAST_BEAT);

  // pair state register and first-sample hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAIR_EVEN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hold_en) hold_q <= bus.in_data;
    end
  end

  // pair next-state: disabling capture discards any half-built pair
  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    push    = 1'b0;
    if (!enable) begin
      state_d = PAIR_EVEN;
    end else if (bus.in_valid) begin
      case (state_q)
        PAIR_EVEN: begin
          hold_en = 1'b1;
          state_d = PAIR_ODD;
        end
        PAIR_ODD: begin
          push    = 1'b1;
          state_d = PAIR_EVEN;
        end
        default: state_d = PAIR_EVEN;
      endcase
    end
  end

  // beat counter counts delivered beats only, so dropped beats never shorten a packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      beat_cnt <= '0;
    else if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
  end

  // sticky overflow; a new drop beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
  // saturating drop counter; clear and drop together leave a count of one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               drop_count <= '0;
    else if (overflow_clr)                 drop_count <= drop ? 32'd1 : 32'd0;
    else if (drop && (drop_count != '1))   drop_count <= drop_count + 32'd1;
  end
`endif

  cs8_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (bus.m_axis_tdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_cs8_axis_packer.sv
// Bench for cs8_axis_packer: directed scenarios followed by a random phase,
// all compared cycle by cycle against a queue-based model of the packer.
module tb_cs8_axis_packer;
  import cs8_pkg::*;

  localparam int DEPTH = 4;
  localparam int PLEN  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       overflow;
  logic [2:0] fifo_level;
`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  cs8_axis_packer_if bus ();

  cs8_axis_packer #(
    .FIFO_DEPTH (DEPTH),
    .PKT_LEN    (PLEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .bus          (bus),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .fifo_level   (fifo_level)
`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // reference model: buffered beats, pending first sample, flags, delivered count
  beat_t       mq[$];
  bit          half;
  iq_word_t    held;
  bit          m_ovf;
  int unsigned delivered;
  logic [31:0] m_drop;

  // observed handshake log
  beat_t       got[$];
  int          hs_idx;
  logic [15:0] tl_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    half      = 1'b0;
    held      = '0;
    m_ovf     = 1'b0;
    delivered = 0;
    m_drop    = '0;
  endtask

  task automatic do_reset();
    enable           = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.m_axis_tready = 1'b0;
    overflow_clr     = 1'b0;
    rst              = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // one clock cycle: drive, check outputs against model, advance model
  task automatic cyc(input bit en, input bit v, input logic [15:0] d, input bit rdy, input bit clr);
    bit    exp_valid, pop, push, drop;
    beat_t nb;
    enable            = en;
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.m_axis_tready = rdy;
    overflow_clr      = clr;
    @(negedge clk); #1;
    exp_valid = (mq.size() != 0);
    chk("tvalid", 32'(bus.m_axis_tvalid), 32'(exp_valid));
    if (exp_valid) chk("tdata", bus.m_axis_tdata, mq[0]);
    chk("tlast", 32'(bus.m_axis_tlast), 32'(exp_valid && ((delivered % PLEN) == PLEN - 1)));
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
    chk("drop_count", drop_count, m_drop);
`endif
    if (bus.m_axis_tvalid && rdy) begin
      got.push_back(bus.m_axis_tdata);
      if (bus.m_axis_tlast && hs_idx < 16) tl_seen[hs_idx] = 1'b1;
      hs_idx++;
    end
    pop  = exp_valid && rdy;
    push = 1'b0;
    nb   = '0;
    if (!en) begin
      half = 1'b0;
    end else if (v) begin
      if (!half) begin
        held = d;
        half = 1'b1;
      end else begin
        nb   = {d, held};
        push = 1'b1;
        half = 1'b0;
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      delivered++;
    end
    drop = 1'b0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(nb);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drop = drop ? 32'd1 : 32'd0;
    else if (drop && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t exp4[5];
    bit    r_en, r_v, r_rdy, r_clr;

    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.m_axis_tready = 1'b0;
    model_reset();
    hs_idx  = 0;
    tl_seen = '0;

    // reset state
    #1;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic pairing and one-cycle latency
    cyc(1, 1, 16'h0101, 1, 0);
    chk("t1_no_beat_yet", 32'(bus.m_axis_tvalid), 32'd0);
    cyc(1, 1, 16'h0202, 1, 0);
    chk("t1_first_valid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("t1_first_data", bus.m_axis_tdata, 32'h0202_0101);
    cyc(1, 1, 16'h0303, 1, 0);
    cyc(1, 1, 16'h0404, 1, 0);
    chk("t1_second_data", bus.m_axis_tdata, 32'h0404_0303);
    cyc(1, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 1, 0);

    // packet framing: 16 samples -> 8 beats, tlast on beats 3 and 7
    do_reset();
    hs_idx  = 0;
    tl_seen = '0;
    for (int i = 1; i <= 16; i++) cyc(1, 1, 16'(i * 16'h0101), 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0000, 1, 0);
    chk("t2_beats", 32'(hs_idx), 32'd8);
    chk("t2_tlast_pos", 32'(tl_seen), 32'h0088);

    // partial pair discarded when enable drops
    do_reset();
    got.delete();
    cyc(1, 1, 16'h1111, 1, 0);
    cyc(0, 1, 16'h2222, 1, 0);
    cyc(1, 1, 16'hAAAA, 1, 0);
    cyc(1, 1, 16'hBBBB, 1, 0);
    chk("t3_data", bus.m_axis_tdata, 32'hBBBB_AAAA);
    cyc(1, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 1, 0);
    chk("t3_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("t3_only_beat", got[0], 32'hBBBB_AAAA);

    // overflow with stalled sink, then push+pop on a full FIFO
    do_reset();
    got.delete();
    for (int i = 1; i <= 12; i++) cyc(1, 1, 16'(i * 16'h0101), 0, 0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd4);
`ifdef CS8_AXIS_PACKER_DROP_CNT_EN
    chk("t4_drop_count", drop_count, 32'd2);
`endif
    cyc(1, 0, 16'h0000, 0, 1);
    chk("t5_cleared", 32'(overflow), 32'd0);
    cyc(1, 1, 16'h0D0D, 0, 0);
    cyc(1, 1, 16'h0E0E, 1, 0);
    chk("t5_level_full", 32'(fifo_level), 32'd4);
    chk("t5_no_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0000, 1, 0);
    exp4[0] = 32'h0202_0101;
    exp4[1] = 32'h0404_0303;
    exp4[2] = 32'h0606_0505;
    exp4[3] = 32'h0808_0707;
    exp4[4] = 32'h0E0E_0D0D;
    chk("t4_drained", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("t4_order", got[i], exp4[i]);
    end

    // asynchronous reset mid-packet with tvalid and tlast high
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 1, 16'(i * 16'h0101), 1, 0);
    for (int i = 9; i <= 18; i++) cyc(1, 1, 16'(i * 16'h0101), 0, 0);
    chk("t6_pre_tlast", 32'(bus.m_axis_tlast), 32'd1);
    chk("t6_pre_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("t6_async_tlast", 32'(bus.m_axis_tlast), 32'd0);
    chk("t6_async_overflow", 32'(overflow), 32'd0);
    chk("t6_async_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst     = 1'b0;
    hs_idx  = 0;
    tl_seen = '0;
    for (int i = 1; i <= 10; i++) cyc(1, 1, 16'(i * 16'h1001), 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0000, 1, 0);
    chk("t6_beats", 32'(hs_idx), 32'd5);
    chk("t6_tlast_pos", 32'(tl_seen), 32'h0008);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r_en  = ($urandom_range(0, 15) != 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_rdy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      r_clr = ($urandom_range(0, 31) == 0);
      cyc(r_en, r_v, 16'($urandom), r_rdy, r_clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
